process_scheduler: RTL and testbench
====================================

// Module: process_scheduler
// PURPOSE
//  Round-robin time-slice scheduler that sequences the program counter between user programs.
//  Holds a per-slot context table (saved relative PC, ready bit) and counts retired instructions against a quantum.
//  Raises preempt to trap the PC into the kernel, then dispatches the next ready program via an lpc pulse.
//  Sits beside the PC. Slot 0 is the kernel at offset 0; slot s runs at offset s*PROG_STRIDE.
// PARAMETERS
//  NUM_SLOTS        4     total slots incl. kernel slot 0 (user slots 1..NUM_SLOTS-1)
//  SLOT_W           2     width of slot index, = clog2(NUM_SLOTS)
//  ADDR_W           32    PC address width
//  PROG_STRIDE      1000  address offset per slot
//  DEFAULT_QUANTUM  5     quantum after reset; 0 = never preempt
// PORTS
//  clock          in   1          system clock, rising edge
//  reset          in   1          synchronous, active-high
//  stop           in   1          halts instruction counting and RUN-state transitions
//  quantum_wr     in   1          load quantum_in into quantum register
//  quantum_in     in   32         new quantum value
//  load_valid     in   1          register a program: ctx[load_slot] <= load_pc, ready set
//  load_slot      in   SLOT_W     slot being loaded
//  load_pc        in   ADDR_W     relative start PC
//  sched_req      in   1          kernel requests dispatch of next program
//  inst_retire    in   1          one user instruction retired this cycle
//  prog_end       in   1          running program executed its end instruction
//  save_valid     in   1          PC presents switched-out absolute PC
//  save_pc        in   ADDR_W     absolute PC to resume at
//  preempt        out  1          one-cycle pulse: PC must trap to kernel
//  lpc            out  1          one-cycle pulse: PC loads dispatch_pc + slot offset
//  dispatch_pc    out  ADDR_W     relative PC of dispatched program
//  dispatch_slot  out  SLOT_W     slot being dispatched
//  cur_slot       out  SLOT_W     slot currently owning the PC (0 = kernel)
//  idle           out  1          sched_req seen with no ready user slot
//  ready_mask     out  NUM_SLOTS  ready bits; bit 0 always 0
// BEHAVIOUR
//  Reset values:
//   - All outputs 0; state KERNEL; ctx table and ready bits 0.
//   - quantum = DEFAULT_QUANTUM; inst_cnt = 0; last_slot = 0.
//  KERNEL:
//   - sched_req with no ready user slot: idle=1, stay in KERNEL.
//   - sched_req with a ready user slot: idle=0, go to PICK.
//  PICK (1 cycle):
//   - Round-robin search starting at last_slot+1 over 1..NUM_SLOTS-1 with wrap; slot 0 is never picked.
//   - Latch the first ready slot as sel; go to DISPATCH.
//  DISPATCH (1 cycle):
//   - lpc=1, dispatch_slot=sel, dispatch_pc=ctx[sel].
//   - cur_slot<=sel, inst_cnt<=0; go to RUN.
//   - Latency from sched_req to lpc is exactly 2 cycles.
//  RUN:
//   - inst_retire && !stop increments inst_cnt, saturating at 2^32-1.
//   - prog_end (wins over expiry): clear ready[cur_slot], set discard, no preempt; go to WAIT_SAVE.
//   - Else quantum!=0 && next count >= quantum: preempt pulse this cycle; go to WAIT_SAVE.
//   - Lowering quantum below inst_cnt causes preempt on the next non-stopped RUN cycle.
//   - While stop=1: no count, no transition.
//  WAIT_SAVE:
//   - Wait for save_valid. If !discard: ctx[cur_slot] <= save_pc - cur_slot*PROG_STRIDE (mod 2^ADDR_W).
//   - Then last_slot<=cur_slot, cur_slot<=0, discard<=0; go to KERNEL.
//   - save_valid in any other state is ignored.
//  load_valid:
//   - Accepted in any state, except load_slot==0 or (RUN/WAIT_SAVE && load_slot==cur_slot), which are dropped.
//   - A load to the same slot in the same cycle as a WAIT_SAVE write wins over the save.
//  quantum_wr: accepted in any state; the new value is used from the next cycle.
//  reset mid-operation: next cycle equals the post-reset state; no pending pulse survives.
// STRUCTURE
//  Package sched_pkg: state encoding (KERNEL, PICK, DISPATCH, RUN, WAIT_SAVE), PROG_STRIDE, SLOT_W.
//  Sub-module rr_picker: combinational round-robin search (ready_mask, last_slot -> sel, found).
//  Context table: register array of NUM_SLOTS x ADDR_W; entry 0 is unused.
// TESTING
//  1. Reset, then sched_req -> idle=1, state stays KERNEL, lpc never asserted.
//  2. Load slot1 pc=0 and slot2 pc=4, quantum=3; sched_req -> lpc 2 cycles later with slot1/pc0.
//     Three retires -> preempt on the 3rd. save_pc=1003 -> ctx[1]=3.
//     Next sched_req dispatches slot2 pc4.
//  3. Round-robin wrap with slots 1,2,3 ready and last_slot=3 -> slot1 picked; only slot2 ready, last=2 -> slot2 again.
//  4. prog_end and quantum expiry in the same cycle -> no preempt, ready[cur] cleared, save_pc discarded.
//  5. quantum=0 with 100 retires -> no preempt. stop=1 during RUN -> inst_cnt frozen.
//  6. reset asserted in RUN with inst_cnt=2 -> next cycle all outputs 0, ready_mask=0, quantum=5.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared definitions for the round-robin process scheduler: slot geometry,
// address stride between program images and the scheduler state encoding.
package sched_pkg;

    localparam int NUM_SLOTS       = 4;
    localparam int SLOT_W          = 2;
    localparam int ADDR_W          = 32;
    localparam int PROG_STRIDE     = 1000;
    localparam int DEFAULT_QUANTUM = 5;

    typedef enum logic [2:0] {
        ST_KERNEL,
        ST_PICK,
        ST_DISPATCH,
        ST_RUN,
        ST_WAIT_SAVE
    } state_t;

    // Base address of a slot's program image; slot 0 (kernel) sits at 0.
    function automatic logic [ADDR_W-1:0] slot_offset(input logic [SLOT_W-1:0] s);
        return ADDR_W'(s) * ADDR_W'(PROG_STRIDE);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search over user slots 1..NUM_SLOTS-1, starting
// just after the last slot that ran and wrapping; slot 0 is never selected.
module rr_picker
    import sched_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] i_ready,
    input  logic [SLOT_W-1:0]    i_last,
    output logic [SLOT_W-1:0]    o_sel,
    output logic                 o_found
);

    logic [SLOT_W-1:0] w_cand;

    always_comb begin
        o_sel   = '0;
        o_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k < NUM_SLOTS; k++) begin
            w_cand = SLOT_W'(((int'(i_last) + k - 1) % (NUM_SLOTS - 1)) + 1);
            if (!o_found && i_ready[w_cand]) begin
                o_found = 1'b1;
                o_sel   = w_cand;
            end
        end
    end

endmodule

// File: rtl/process_scheduler.sv
// Time-slice scheduler beside the PC: keeps per-slot saved PCs, counts retired
// instructions against a quantum, traps to the kernel and dispatches programs.
module process_scheduler
    import sched_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stop,
    input  logic                 quantum_wr,
    input  logic [31:0]          quantum_in,
    input  logic                 load_valid,
    input  logic [SLOT_W-1:0]    load_slot,
    input  logic [ADDR_W-1:0]    load_pc,
    input  logic                 sched_req,
    input  logic                 inst_retire,
    input  logic                 prog_end,
    input  logic                 save_valid,
    input  logic [ADDR_W-1:0]    save_pc,
    output logic                 preempt,
    output logic                 lpc,
    output logic [ADDR_W-1:0]    dispatch_pc,
    output logic [SLOT_W-1:0]    dispatch_slot,
    output logic [SLOT_W-1:0]    cur_slot,
    output logic                 idle,
    output logic [NUM_SLOTS-1:0] ready_mask
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_ctx [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] r_ready;
    logic [31:0]         r_quantum;
    logic [31:0]         r_inst_cnt;
    logic [SLOT_W-1:0]   r_last_slot;
    logic [SLOT_W-1:0]   r_cur_slot;
    logic [SLOT_W-1:0]   r_sel;
    logic                r_discard;
    logic                r_idle;

    logic [SLOT_W-1:0]   w_pick;
    logic                w_found;
    logic [31:0]         w_cnt_nxt;
    logic                w_expire;
    logic                w_load_ok;

    rr_picker u_picker (
        .i_ready (r_ready),
        .i_last  (r_last_slot),
        .o_sel   (w_pick),
        .o_found (w_found)
    );

    assign w_cnt_nxt = (inst_retire && (r_inst_cnt != '1)) ? r_inst_cnt + 32'd1 : r_inst_cnt;
    assign w_expire  = (r_quantum != 32'd0) && (w_cnt_nxt >= r_quantum);

    // The running program's own context is owned by the PC until it is saved.
    assign w_load_ok = load_valid && (load_slot != '0) &&
                       !(((r_state == ST_RUN) || (r_state == ST_WAIT_SAVE)) &&
                         (load_slot == r_cur_slot));

    assign cur_slot   = r_cur_slot;
    assign idle       = r_idle;
    assign ready_mask = r_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_KERNEL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        preempt       = 1'b0;
        lpc           = 1'b0;
        dispatch_pc   = '0;
        dispatch_slot = '0;
        case (r_state)
            ST_KERNEL: begin
                if (sched_req && w_found) begin
                    w_state_nxt = ST_PICK;
                end
            end
            ST_PICK: begin
                w_state_nxt = w_found ? ST_DISPATCH : ST_KERNEL;
            end
            ST_DISPATCH: begin
                lpc           = 1'b1;
                dispatch_slot = r_sel;
                dispatch_pc   = r_ctx[r_sel];
                w_state_nxt   = ST_RUN;
            end
            ST_RUN: begin
                // A finishing program is never preempted, even on its last quantum tick.
                if (!stop) begin
                    if (prog_end) begin
                        w_state_nxt = ST_WAIT_SAVE;
                    end else if (w_expire) begin
                        preempt     = 1'b1;
                        w_state_nxt = ST_WAIT_SAVE;
                    end
                end
            end
            ST_WAIT_SAVE: begin
                if (save_valid) begin
                    w_state_nxt = ST_KERNEL;
                end
            end
            default: w_state_nxt = ST_KERNEL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_ctx[i] <= '0;
            end
            r_ready     <= '0;
            r_quantum   <= 32'(DEFAULT_QUANTUM);
            r_inst_cnt  <= '0;
            r_last_slot <= '0;
            r_cur_slot  <= '0;
            r_sel       <= '0;
            r_discard   <= 1'b0;
            r_idle      <= 1'b0;
        end else begin
            if (quantum_wr) begin
                r_quantum <= quantum_in;
            end
            case (r_state)
                ST_KERNEL: begin
                    if (sched_req) begin
                        r_idle <= !w_found;
                    end
                end
                ST_PICK: begin
                    if (w_found) begin
                        r_sel <= w_pick;
                    end
                end
                ST_DISPATCH: begin
                    r_cur_slot <= r_sel;
                    r_inst_cnt <= '0;
                end
                ST_RUN: begin
                    if (!stop) begin
                        r_inst_cnt <= w_cnt_nxt;
                        if (prog_end) begin
                            r_ready[r_cur_slot] <= 1'b0;
                            r_discard           <= 1'b1;
                        end
                    end
                end
                ST_WAIT_SAVE: begin
                    // Saved PC is absolute; the table holds it relative to the slot base.
                    if (save_valid) begin
                        if (!r_discard) begin
                            r_ctx[r_cur_slot] <= save_pc - slot_offset(r_cur_slot);
                        end
                        r_last_slot <= r_cur_slot;
                        r_cur_slot  <= '0;
                        r_discard   <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (w_load_ok) begin
                r_ctx[load_slot]   <= load_pc;
                r_ready[load_slot] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a reference model.
module tb_process_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stop = 1'b0;
    logic        quantum_wr = 1'b0;
    logic [31:0] quantum_in = '0;
    logic        load_valid = 1'b0;
    logic [1:0]  load_slot = '0;
    logic [31:0] load_pc = '0;
    logic        sched_req = 1'b0;
    logic        inst_retire = 1'b0;
    logic        prog_end = 1'b0;
    logic        save_valid = 1'b0;
    logic [31:0] save_pc = '0;
    logic        preempt;
    logic        lpc;
    logic [31:0] dispatch_pc;
    logic [1:0]  dispatch_slot;
    logic [1:0]  cur_slot;
    logic        idle;
    logic [3:0]  ready_mask;

    int errors = 0;
    int checks = 0;

    process_scheduler dut (
        .clock         (clock),
        .reset         (reset),
        .stop          (stop),
        .quantum_wr    (quantum_wr),
        .quantum_in    (quantum_in),
        .load_valid    (load_valid),
        .load_slot     (load_slot),
        .load_pc       (load_pc),
        .sched_req     (sched_req),
        .inst_retire   (inst_retire),
        .prog_end      (prog_end),
        .save_valid    (save_valid),
        .save_pc       (save_pc),
        .preempt       (preempt),
        .lpc           (lpc),
        .dispatch_pc   (dispatch_pc),
        .dispatch_slot (dispatch_slot),
        .cur_slot      (cur_slot),
        .idle          (idle),
        .ready_mask    (ready_mask)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Program lifecycle expressed as: waiting in kernel, a pick pending,
    // a dispatch pending, a program running, or the switch-out save pending.
    bit          started = 1'b0;
    bit          m_rdy [4];
    logic [31:0] m_ctx [4];
    logic [31:0] m_q;
    logic [31:0] m_cnt;
    int          m_last, m_cur, m_sel;
    bit          m_idle, m_disc;
    bit          m_pick, m_disp, m_run, m_save;

    function automatic int rr_pick(input int last);
        int s;
        s = last;
        repeat (3) begin
            s = (s == 3) ? 1 : s + 1;
            if (m_rdy[s]) return s;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_rdy[i] = 1'b0;
            m_ctx[i] = '0;
        end
        m_q = 32'd5; m_cnt = '0; m_last = 0; m_cur = 0; m_sel = 0;
        m_idle = 0; m_disc = 0; m_pick = 0; m_disp = 0; m_run = 0; m_save = 0;
    endtask

    logic [31:0] e_next;
    bit          e_pre, e_load, e_any;
    int          e_pk;

    always @(negedge clock) begin
        e_next = (inst_retire && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
        e_pre  = m_run && !stop && !prog_end && (m_q != 0) && (e_next >= m_q);
        if (started) begin
            chk("preempt", 32'(preempt), 32'(e_pre));
            chk("lpc", 32'(lpc), 32'(m_disp));
            chk("dispatch_slot", 32'(dispatch_slot), m_disp ? 32'(m_sel) : 32'd0);
            chk("dispatch_pc", dispatch_pc, m_disp ? m_ctx[m_sel] : 32'd0);
            chk("cur_slot", 32'(cur_slot), 32'(m_cur));
            chk("idle", 32'(idle), 32'(m_idle));
            chk("ready_mask", 32'(ready_mask), {28'd0, m_rdy[3], m_rdy[2], m_rdy[1], 1'b0});
        end
        if (reset) begin
            model_reset();
            started = 1'b1;
        end else if (started) begin
            e_load = load_valid && load_slot != 0 &&
                     !((m_run || m_save) && int'(load_slot) == m_cur);
            e_any  = m_rdy[1] || m_rdy[2] || m_rdy[3];
            if (m_disp) begin
                m_cur = m_sel; m_cnt = '0; m_disp = 0; m_run = 1;
            end else if (m_pick) begin
                e_pk = rr_pick(m_last);
                m_pick = 0;
                if (e_pk != 0) begin
                    m_sel = e_pk; m_disp = 1;
                end
            end else if (m_run) begin
                if (!stop) begin
                    m_cnt = e_next;
                    if (prog_end) begin
                        m_rdy[m_cur] = 0; m_disc = 1; m_run = 0; m_save = 1;
                    end else if (e_pre) begin
                        m_run = 0; m_save = 1;
                    end
                end
            end else if (m_save) begin
                if (save_valid) begin
                    if (!m_disc) m_ctx[m_cur] = save_pc - 32'(m_cur * 1000);
                    m_last = m_cur; m_cur = 0; m_disc = 0; m_save = 0;
                end
            end else if (sched_req) begin
                if (e_any) begin
                    m_idle = 0; m_pick = 1;
                end else begin
                    m_idle = 1;
                end
            end
            if (e_load) begin
                m_ctx[load_slot] = load_pc;
                m_rdy[load_slot] = 1;
            end
            if (quantum_wr) m_q = quantum_in;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input int s, input int pc);
        load_valid = 1; load_slot = 2'(s); load_pc = 32'(pc);
        tick();
        load_valid = 0;
    endtask

    task automatic set_quantum(input int q);
        quantum_wr = 1; quantum_in = 32'(q);
        tick();
        quantum_wr = 0;
    endtask

    task automatic dispatch_expect(input int s, input int pc);
        sched_req = 1;
        tick();
        sched_req = 0;
        #1 chk("pick_no_lpc", 32'(lpc), 32'd0);
        tick();
        #1;
        chk("disp_lpc", 32'(lpc), 32'd1);
        chk("disp_slot", 32'(dispatch_slot), 32'(s));
        chk("disp_pc", dispatch_pc, 32'(pc));
        tick();
    endtask

    task automatic retire_n(input int n, input bit pre_last);
        inst_retire = 1;
        for (int i = 0; i < n; i++) begin
            #1;
            if (i == n - 1) chk("retire_preempt", 32'(preempt), 32'(pre_last));
            tick();
        end
        inst_retire = 0;
    endtask

    task automatic end_prog();
        prog_end = 1;
        #1 chk("end_no_preempt", 32'(preempt), 32'd0);
        tick();
        prog_end = 0;
    endtask

    task automatic do_save(input int pc);
        save_valid = 1; save_pc = 32'(pc);
        tick();
        save_valid = 0;
    endtask

    initial begin
        reset = 1;
        repeat (3) tick();
        reset = 0;
        #1;
        chk("rst_ready", 32'(ready_mask), 32'd0);
        chk("rst_cur", 32'(cur_slot), 32'd0);
        chk("rst_idle", 32'(idle), 32'd0);

        // Nothing ready: idle, no dispatch
        sched_req = 1;
        tick();
        sched_req = 0;
        #1 chk("idle_set", 32'(idle), 32'd1);
        repeat (3) begin
            tick();
            chk("idle_no_lpc", 32'(lpc), 32'd0);
        end

        // Basic dispatch, quantum expiry and context save
        do_load(1, 0);
        do_load(2, 4);
        set_quantum(3);
        #1 chk("loaded_mask", 32'(ready_mask), 32'd6);
        dispatch_expect(1, 0);
        chk("run_cur", 32'(cur_slot), 32'd1);
        retire_n(3, 1);
        do_save(1003);
        dispatch_expect(2, 4);
        retire_n(3, 1);
        do_save(2010);

        // Round-robin ordering and wrap
        do_load(3, 9);
        dispatch_expect(3, 9);
        retire_n(3, 1);
        do_save(3020);
        dispatch_expect(1, 3);

        // prog_end coinciding with quantum expiry
        retire_n(2, 0);
        inst_retire = 1;
        end_prog();
        inst_retire = 0;
        do_save(1500);
        #1 chk("discard_mask", 32'(ready_mask), 32'd12);

        // Only slot 2 ready after it last ran -> picked again
        dispatch_expect(2, 10);
        end_prog();
        do_save(2999);
        do_load(2, 40);
        dispatch_expect(3, 20);
        end_prog();
        do_save(3001);
        dispatch_expect(2, 40);
        retire_n(3, 1);
        do_save(2041);
        dispatch_expect(2, 41);

        // quantum 0 never preempts; lowering quantum preempts; stop freezes
        set_quantum(0);
        inst_retire = 1;
        repeat (100) begin
            #1 chk("q0_no_preempt", 32'(preempt), 32'd0);
            tick();
        end
        stop = 1;
        set_quantum(3);
        repeat (4) begin
            #1 chk("stopped_no_preempt", 32'(preempt), 32'd0);
            tick();
        end
        stop = 0; inst_retire = 0;
        #1 chk("lowered_q_preempt", 32'(preempt), 32'd1);
        tick();
        do_save(2045);
        dispatch_expect(2, 45);
        retire_n(2, 0);
        stop = 1; inst_retire = 1;
        repeat (4) begin
            #1 chk("stop_frozen", 32'(preempt), 32'd0);
            tick();
        end
        stop = 0;
        #1 chk("stop_release_preempt", 32'(preempt), 32'd1);
        tick();
        inst_retire = 0;
        do_save(2050);

        // Reset mid-run
        dispatch_expect(2, 50);
        retire_n(2, 0);
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("mid_rst_mask", 32'(ready_mask), 32'd0);
        chk("mid_rst_cur", 32'(cur_slot), 32'd0);
        chk("mid_rst_lpc", 32'(lpc), 32'd0);
        chk("mid_rst_preempt", 32'(preempt), 32'd0);
        do_load(1, 0);
        dispatch_expect(1, 0);
        retire_n(4, 0);
        retire_n(1, 1);
        do_save(1000);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            reset       = ($urandom_range(0, 399) == 0);
            stop        = ($urandom_range(0, 9) == 0);
            sched_req   = ($urandom_range(0, 9) < 3);
            inst_retire = ($urandom_range(0, 1) == 1);
            prog_end    = ($urandom_range(0, 19) == 0);
            save_valid  = ($urandom_range(0, 9) < 3);
            save_pc     = 32'($urandom_range(0, 3) * 1000 + $urandom_range(0, 99));
            load_valid  = ($urandom_range(0, 9) == 0);
            load_slot   = 2'($urandom_range(0, 3));
            load_pc     = 32'($urandom_range(0, 200));
            quantum_wr  = ($urandom_range(0, 29) == 0);
            quantum_in  = 32'($urandom_range(0, 6));
            tick();
        end
        reset = 0; stop = 0; sched_req = 0; inst_retire = 0; prog_end = 0;
        save_valid = 0; load_valid = 0; quantum_wr = 0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
